// File: rtl/pwr_domain_seq.sv
// Power-gating sequencer: clock stop -> isolate -> retention save -> switch off on sleep, reverse on wake.
// Outputs are registered from the next-state decode; a synchronized switch ack is timed out into a sticky FAULT.
module pwr_domain_seq #(
  parameter int SAVE_CYCLES    = 4,
  parameter int RESTORE_CYCLES = 4,
  parameter int ACK_TIMEOUT    = 64,
  parameter int CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SLEEP_REQ,
  input  logic       WAKE_REQ,
  input  logic       PSW_ACK,
  output logic       CLK_EN,
  output logic       ISO_N,
  output logic       SAVE,
  output logic       RESTORE,
  output logic       PSW_EN,
  output logic       BUSY,
  output logic       ERR,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_ON       = 4'd0,
    S_CLK_STOP = 4'd1,
    S_ISOLATE  = 4'd2,
    S_SAVE     = 4'd3,
    S_PSW_OFF  = 4'd4,
    S_OFF      = 4'd5,
    S_PSW_ON   = 4'd6,
    S_RESTORE  = 4'd7,
    S_DEISO    = 4'd8,
    S_FAULT    = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] SAVE_LAST    = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_meta_q, ack_s_q;
  logic             clk_en_q, clk_en_d;
  logic             iso_n_q, iso_n_d;
  logic             save_q, save_d;
  logic             restore_q, restore_d;
  logic             psw_en_q, psw_en_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_ON;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      clk_en_q   <= 1'b1;
      iso_n_q    <= 1'b1;
      save_q     <= 1'b0;
      restore_q  <= 1'b0;
      psw_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_meta_q <= PSW_ACK;
      ack_s_q    <= ack_meta_q;
      clk_en_q   <= clk_en_d;
      iso_n_q    <= iso_n_d;
      save_q     <= save_d;
      restore_q  <= restore_d;
      psw_en_q   <= psw_en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // An arriving ack wins over a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ON:       if (SLEEP_REQ) state_d = S_CLK_STOP;
      S_CLK_STOP: state_d = S_ISOLATE;
      S_ISOLATE:  state_d = S_SAVE;
      S_SAVE:     if (cnt_q == SAVE_LAST) state_d = S_PSW_OFF;
      S_PSW_OFF: begin
        if (!ack_s_q)              state_d = S_OFF;
        else if (cnt_q == ACK_LAST) state_d = S_FAULT;
      end
      S_OFF:      if (WAKE_REQ) state_d = S_PSW_ON;
      S_PSW_ON: begin
        if (ack_s_q)                state_d = S_RESTORE;
        else if (cnt_q == ACK_LAST) state_d = S_FAULT;
      end
      S_RESTORE:  if (cnt_q == RESTORE_LAST) state_d = S_DEISO;
      S_DEISO:    state_d = S_ON;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {S_SAVE, S_RESTORE, S_PSW_OFF, S_PSW_ON}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs decode the upcoming state so they flip on the same edge as state_q.
  always_comb begin
    clk_en_d  = 1'b0;
    iso_n_d   = 1'b0;
    save_d    = 1'b0;
    restore_d = 1'b0;
    psw_en_d  = 1'b1;
    busy_d    = !(state_d inside {S_ON, S_OFF});
    err_d     = err_q;
    unique case (state_d)
      S_ON: begin
        clk_en_d = 1'b1;
        iso_n_d  = 1'b1;
      end
      S_CLK_STOP: iso_n_d   = 1'b1;
      S_ISOLATE:  iso_n_d   = 1'b0;
      S_SAVE:     save_d    = 1'b1;
      S_PSW_OFF:  psw_en_d  = 1'b0;
      S_OFF:      psw_en_d  = 1'b0;
      S_PSW_ON:   psw_en_d  = 1'b1;
      S_RESTORE:  restore_d = 1'b1;
      S_DEISO:    iso_n_d   = 1'b1;
      default: begin
        psw_en_d = psw_en_q;
        err_d    = 1'b1;
      end
    endcase
  end

  assign CLK_EN  = clk_en_q;
  assign ISO_N   = iso_n_q;
  assign SAVE    = save_q;
  assign RESTORE = restore_q;
  assign PSW_EN  = psw_en_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;
  assign STATE   = state_q;

endmodule
